// File: rtl/spi_cmd_master_if.sv
// Command/reply and SPI pin bundle for spi_cmd_master.
// master is the view of spi_cmd_master itself; slave is the view of the host/slave side.
interface spi_cmd_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [9:0] cmd_word;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       busy;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;

   modport master (
      input  cmd_valid, cmd_word, MISO,
      output cmd_ready, rd_valid, rd_data, busy, SS_n, MOSI
   );

   modport slave (
      output cmd_valid, cmd_word, MISO,
      input  cmd_ready, rd_valid, rd_data, busy, SS_n, MOSI
   );
endinterface

// File: rtl/spi_cmd_master.sv
// Serialises 10-bit command words into SS_n/MOSI frames for the SPI RAM slave.
// Read-data frames also collect an 8-bit reply from MISO.
module spi_cmd_master #(
   parameter int READ_LATENCY = 2,
   parameter int GAP_CYCLES   = 1
) (
   input logic              clk,
   input logic              rst_n,
   spi_cmd_master_if.master bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEAD    = 3'd1;
   localparam logic [2:0] S_SHIFT   = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_CAPTURE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
   localparam logic [2:0] S_GAP     = 3'd6;

   localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY - 1);
   localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

   logic [2:0] state, state_nxt;
   logic [3:0] bit_cnt, wait_cnt;
   logic [9:0] shift_reg;
   logic       is_read;
   logic [7:0] rx_shift;
   logic [7:0] rd_data_q;
   logic       rd_valid_q;
   logic       ss_n_q;
   logic       mosi_q;
   logic       busy_q;

   assign bus.cmd_ready = (state == S_IDLE);
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.busy      = busy_q;
   assign bus.SS_n      = ss_n_q;
   assign bus.MOSI      = mosi_q;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (bus.cmd_valid) state_nxt = S_LEAD;
         S_LEAD:    state_nxt = S_SHIFT;
         S_SHIFT:   if (bit_cnt == 4'd9) state_nxt = is_read ? S_WAIT : S_GAP;
         S_WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = S_CAPTURE;
         S_CAPTURE: if (bit_cnt == 4'd7) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_GAP;
         S_GAP:     if (wait_cnt == GAP_LAST) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from state_nxt so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         bit_cnt    <= 4'd0;
         wait_cnt   <= 4'd0;
         shift_reg  <= 10'd0;
         is_read    <= 1'b0;
         rx_shift   <= 8'd0;
         rd_data_q  <= 8'd0;
         rd_valid_q <= 1'b0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state_nxt != state) begin
            bit_cnt  <= 4'd0;
            wait_cnt <= 4'd0;
         end else begin
            if (state == S_SHIFT || state == S_CAPTURE) bit_cnt  <= bit_cnt + 4'd1;
            if (state == S_WAIT  || state == S_GAP)     wait_cnt <= wait_cnt + 4'd1;
         end

         // The word is shifted out MSB first; the read flag is kept aside since the top bits shift away.
         if (state == S_IDLE && bus.cmd_valid) begin
            shift_reg <= bus.cmd_word;
            is_read   <= &bus.cmd_word[9:8];
         end else if (state_nxt == S_SHIFT) begin
            shift_reg <= {shift_reg[8:0], 1'b0};
         end
         mosi_q <= (state_nxt == S_SHIFT) ? shift_reg[9] : 1'b0;

         if (state == S_CAPTURE) rx_shift <= {rx_shift[6:0], bus.MISO};
         if (state == S_CAPTURE && state_nxt == S_DONE) rd_data_q <= {rx_shift[6:0], bus.MISO};
         rd_valid_q <= (state_nxt == S_DONE);

         ss_n_q <= (state_nxt == S_IDLE) || (state_nxt == S_GAP);
         busy_q <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: write, read, back-to-back, busy-ignore and mid-frame reset.
module tb_spi_cmd_master;

   logic clk;
   logic rst_n;
   int   ntests = 0;
   int   nfail  = 0;

   spi_cmd_master_if bus ();

   spi_cmd_master #(.READ_LATENCY(2), .GAP_CYCLES(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic ss_a [60];
   logic mo_a [60];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one command at a negedge while idle and follows the frame cycle by cycle.
   // MISO carries rbyte MSB first during the 8 capture cycles (frame cycles 13..20) and 1 elsewhere.
   task automatic frame(input logic [9:0] w, input logic [7:0] rbyte,
                        input int inj_c, input logic [9:0] inj_w, input int stop_low,
                        output int low, output logic [10:0] mosi, output int nrv,
                        output logic [7:0] rvd, output int ready_c);
      low = 0; mosi = '0; nrv = 0; rvd = '0; ready_c = -1;
      bus.cmd_word  = w;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (c == inj_c) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_word  = inj_w;
         end else if (c == inj_c + 1) begin
            bus.cmd_valid = 1'b0;
         end
         if (bus.rd_valid) begin
            nrv++;
            rvd = bus.rd_data;
         end
         if (bus.cmd_ready) begin
            ready_c = c;
            break;
         end
         if (!bus.SS_n) begin
            if (low < 11) mosi[4'(10 - low)] = bus.MOSI;
            bus.MISO = (low >= 13 && low < 21) ? rbyte[3'(20 - low)] : 1'b1;
            low++;
         end else begin
            bus.MISO = 1'b1;
         end
         if (stop_low > 0 && low == stop_low) break;
         @(negedge clk);
      end
   endtask

   initial begin
      int          low, nrv, rc, rise1, fall2, tot;
      logic [10:0] mosi, m1, m2;
      logic [7:0]  rvd;

      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_word  = '0;
      bus.MISO      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ss_n",     32'(bus.SS_n),     32'd1);
      chk("rst_mosi",     32'(bus.MOSI),     32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_rd_data",  32'(bus.rd_data),  32'h00);
      chk("rst_busy",     32'(bus.busy),     32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // Write address 0x0A: LEAD zero then 00_0000_1010.
      frame(10'h00A, 8'h00, -1, 10'h000, 0, low, mosi, nrv, rvd, rc);
      chk("wr_low",   32'(low),  32'd11);
      chk("wr_mosi",  32'(mosi), 32'h00A);
      chk("wr_nrv",   32'(nrv),  32'd0);
      chk("wr_ready", 32'(rc),   32'd12);

      // Read data with reply 0xA5.
      frame(10'h300, 8'hA5, -1, 10'h000, 0, low, mosi, nrv, rvd, rc);
      chk("rd_low",   32'(low),  32'd22);
      chk("rd_mosi",  32'(mosi), 32'h300);
      chk("rd_nrv",   32'(nrv),  32'd1);
      chk("rd_data",  32'(rvd),  32'hA5);
      chk("rd_ready", 32'(rc),   32'd23);
      chk("rd_hold",  32'(bus.rd_data), 32'hA5);

      // Back-to-back: valid held high, word changes right after the first accept.
      bus.cmd_word  = 10'h155;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_word = 10'h2FF;
      for (int c = 0; c < 60; c++) begin
         ss_a[c] = bus.SS_n;
         mo_a[c] = bus.MOSI;
         if (c > 0 && !ss_a[c] && ss_a[c-1]) bus.cmd_valid = 1'b0;
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      rise1 = -1; fall2 = -1; tot = 0;
      for (int c = 0; c < 60; c++) begin
         if (!ss_a[c]) tot++;
         if (rise1 < 0 && ss_a[c]) rise1 = c;
         else if (rise1 >= 0 && fall2 < 0 && !ss_a[c]) fall2 = c;
      end
      m1 = '0; m2 = '0;
      for (int b = 0; b < 11; b++) begin
         m1[4'(10 - b)] = mo_a[b];
         if (fall2 >= 0 && fall2 + b < 60) m2[4'(10 - b)] = mo_a[fall2 + b];
      end
      chk("b2b_rise",  32'(rise1), 32'd11);
      chk("b2b_fall",  32'(fall2), 32'd13);
      chk("b2b_mosi1", 32'(m1),    32'h155);
      chk("b2b_mosi2", 32'(m2),    32'h2FF);
      chk("b2b_total_low", 32'(tot), 32'd22);

      // Busy ignore: a different word pulsed during SHIFT must be dropped.
      frame(10'h1F0, 8'h00, 4, 10'h3FF, 0, low, mosi, nrv, rvd, rc);
      chk("ign_low",   32'(low),  32'd11);
      chk("ign_mosi",  32'(mosi), 32'h1F0);
      chk("ign_nrv",   32'(nrv),  32'd0);
      chk("ign_ready", 32'(rc),   32'd12);
      tot = 0;
      for (int c = 0; c < 20; c++) begin
         if (!bus.SS_n) tot++;
         @(negedge clk);
      end
      chk("ign_no_late_frame", 32'(tot), 32'd0);

      // Reset after 4 MISO bits of a read capture.
      frame(10'h3AA, 8'hF0, -1, 10'h000, 18, low, mosi, nrv, rvd, rc);
      chk("abort_reached", 32'(low), 32'd18);
      rst_n = 1'b0;
      #1;
      chk("abort_ss_n",     32'(bus.SS_n),     32'd1);
      chk("abort_mosi",     32'(bus.MOSI),     32'd0);
      chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("abort_busy",     32'(bus.busy),     32'd0);
      chk("abort_rd_data",  32'(bus.rd_data),  32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
      chk("abort_nrv",   32'(nrv + 32'(bus.rd_valid)), 32'd0);

      frame(10'h3C3, 8'h3C, -1, 10'h000, 0, low, mosi, nrv, rvd, rc);
      chk("fresh_low",  32'(low), 32'd22);
      chk("fresh_nrv",  32'(nrv), 32'd1);
      chk("fresh_data", 32'(rvd), 32'h3C);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- Upstream driver for the single-port-RAM SPI slave; converts parallel 10-bit command words from a host or test controller into serial SPI frames on SS_n/MOSI.
- For read-data commands, it collects the 8-bit reply on MISO and returns it in parallel.
- Synchronous to the same clk as the slave. No separate SCLK: the slave samples MOSI on every posedge clk while SS_n=0.

Parameters:
- READ_LATENCY, 2, cycles SS_n is held low after the last command bit of a read-data frame before MISO sampling starts; legal 1..15.
- GAP_CYCLES, 1, cycles SS_n is held high between frames; legal 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command available.
- cmd_ready  out  1  block can accept a command.
- cmd_word  in  10  {cmd[1:0], payload[7:0]}; cmd 00=write addr, 01=write data, 10=read addr, 11=read data.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  8  byte captured from MISO.
- busy  out  1  high whenever state != IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. Reset values:
  - SS_n=1, MOSI=0, rd_valid=0, rd_data=0x00, busy=0.
  - State=IDLE, all counters=0.
- All outputs are registered except cmd_ready, which is combinational: cmd_ready = (state==IDLE).
- A command is accepted on a posedge where cmd_valid && cmd_ready. cmd_word is latched into shift_reg[9:0]. cmd_valid while busy is ignored (not queued).
- States: IDLE, LEAD, SHIFT, WAIT, CAPTURE, DONE, GAP.
- IDLE: SS_n=1. On accept, go to LEAD.
- LEAD: 1 cycle; SS_n=0, MOSI=0. This gives the slave its IDLE->command-check transition. Go to SHIFT.
- SHIFT: 10 cycles.
  - Cycle i (i=0..9) drives MOSI = latched word bit [9-i], MSB first.
  - bit_cnt counts 0..9.
  - After i=9: go to WAIT if cmd==11, else to GAP.
- WAIT: READ_LATENCY cycles; SS_n=0, MOSI=0. Then go to CAPTURE.
- CAPTURE: 8 cycles; SS_n=0, MOSI=0.
  - Each posedge shifts MISO into rx_shift LSB, so the first sampled bit ends at rd_data[7].
  - After the 8th sample, go to DONE.
- DONE: 1 cycle.
  - rd_data <= rx_shift; rd_valid=1 during this cycle only.
  - SS_n still 0.
  - Go to GAP.
- GAP: SS_n=1, MOSI=0 for GAP_CYCLES cycles. Then go to IDLE; cmd_ready rises the cycle after GAP ends.
- rd_data holds its last value until the next DONE. Write and read-address frames never pulse rd_valid.
- Frame lengths, measured from the first SS_n=0 cycle:
  - Non-read frames: SS_n low for 11 cycles.
  - Read-data frames: SS_n low for 11 + READ_LATENCY + 8 + 1 cycles (22 with defaults).
- Minimum accept-to-accept spacing:
  - Non-read: 1 + 11 + GAP_CYCLES (13 with defaults).
  - Read-data: 1 + 20 + READ_LATENCY + GAP_CYCLES (24 with defaults).
- Reset mid-frame: outputs return to reset values immediately (SS_n=1 asynchronously). The partial frame is abandoned with no rd_valid, and cmd_ready=1 after reset release.
- MISO is ignored outside CAPTURE.
- Counters: 4-bit bit_cnt and wait_cnt, cleared on every state entry. No wrap is possible within legal parameter ranges.

Test Plan:
- Reset: assert rst_n=0 mid-run -> SS_n=1, MOSI=0, rd_valid=0, rd_data=0x00, busy=0, cmd_ready=1 on release.
- Write address 0x00A (cmd_word=10'b00_0000_1010) -> SS_n low exactly 11 cycles; MOSI = 0, then 0,0,0,0,0,0,1,0,1,0; no rd_valid; cmd_ready back after GAP.
- Read data cmd_word=10'h300, slave model drives 0xA5 MSB first starting READ_LATENCY=2 cycles after the last command bit -> rd_valid single pulse with rd_data=0xA5; SS_n low 22 cycles.
- Back-to-back: cmd_valid held high with write-data 0x155, then read-addr 0x2FF -> second frame's SS_n falls exactly GAP_CYCLES+1 cycles after the first frame's SS_n rises; second command is not accepted early.
- Busy ignore: pulse cmd_valid with a different word during SHIFT -> no effect on MOSI stream; not accepted later.
- Reset mid-CAPTURE after 4 MISO bits -> SS_n=1 immediately, no rd_valid; next read frame returns a fresh correct byte, e.g. 0x3C.
